// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle control sequencer: state encodings,
// opcode map, ALU/mux select codes and the bundled control-output record.
package mc_ctrl_pkg;

  localparam int CTRL_STATE_W = 4;

  // One state per clock of the fetch/decode/execute/memory/writeback walk
  typedef enum logic [CTRL_STATE_W-1:0] {
    ST_RESET    = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_WB_R     = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_WB_MEM   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10,
    ST_HALT     = 4'd11
  } state_t;

  // Opcodes 0x0-0x7 are R-type; 0xD and 0xE are undefined
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hB;
  localparam logic [3:0] OP_J    = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_CONST2 = 2'd1;
  localparam logic [1:0] SRCB_OFFSET = 2'd2;

  // Every control line the sequencer drives, decoded as one unit
  typedef struct packed {
    logic       irWrite;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       branchNe;
    logic [1:0] pcSrc;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic       regDstWrite;
    logic       regWrite;
    logic       memToReg;
    logic       halted;
    logic       illegal;
  } ctrl_out_t;

  function automatic logic isRType(input logic [3:0] op);
    return ~op[3];
  endfunction

  function automatic logic isIllegalOp(input logic [3:0] op);
    return (op == 4'hD) || (op == 4'hE);
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bus between the sequencer (master) and the datapath/register file
// (slave). C_MemReady exists only when CTRL_MEMWAIT_EN is defined.
interface mc_ctrl_if;
  logic [3:0] D_Opcode;
`ifdef CTRL_MEMWAIT_EN
  logic       C_MemReady;
`endif
  logic       C_IRWrite;
  logic       C_IorD;
  logic       C_MemRead;
  logic       C_MemWrite;
  logic       C_PCWrite;
  logic       C_PCWriteCond;
  logic       C_BranchNe;
  logic [1:0] C_PCSrc;
  logic       C_ALUSrcA;
  logic [1:0] C_ALUSrcB;
  logic [2:0] C_ALUOp;
  logic       C_RegDstWrite;
  logic       C_RegWrite;
  logic       C_MemToReg;
  logic       C_Halted;
  logic       C_Illegal;

  modport master (
`ifdef CTRL_MEMWAIT_EN
    input  C_MemReady,
`endif
    input  D_Opcode,
    output C_IRWrite, C_IorD, C_MemRead, C_MemWrite,
    output C_PCWrite, C_PCWriteCond, C_BranchNe, C_PCSrc,
    output C_ALUSrcA, C_ALUSrcB, C_ALUOp,
    output C_RegDstWrite, C_RegWrite, C_MemToReg,
    output C_Halted, C_Illegal
  );

  modport slave (
`ifdef CTRL_MEMWAIT_EN
    output C_MemReady,
`endif
    output D_Opcode,
    input  C_IRWrite, C_IorD, C_MemRead, C_MemWrite,
    input  C_PCWrite, C_PCWriteCond, C_BranchNe, C_PCSrc,
    input  C_ALUSrcA, C_ALUSrcB, C_ALUOp,
    input  C_RegDstWrite, C_RegWrite, C_MemToReg,
    input  C_Halted, C_Illegal
  );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Moore output decoder: maps the current state and latched opcode onto every
// control line. With CTRL_MEMWAIT_EN, PC/IR writes in FETCH wait for memory.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [3:0] i_opcode,
  input  logic       i_illegalPending,
`ifdef CTRL_MEMWAIT_EN
  input  logic       i_memReady,
`endif
  output ctrl_out_t  o_ctrl
);

  logic w_fetchGo;

`ifdef CTRL_MEMWAIT_EN
  assign w_fetchGo = i_memReady;
`else
  assign w_fetchGo = 1'b1;
`endif

  // Everything defaults to 0, so RESET (and any unused code) drives nothing
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.memRead = 1'b1;
        o_ctrl.irWrite = w_fetchGo;
        o_ctrl.aluSrcB = SRCB_CONST2;
        o_ctrl.aluOp   = ALU_ADD;
        o_ctrl.pcSrc   = PCSRC_ALU;
        o_ctrl.pcWrite = w_fetchGo;
        o_ctrl.illegal = i_illegalPending;
      end
      ST_DECODE: begin
        o_ctrl.aluSrcB = SRCB_OFFSET;
        o_ctrl.aluOp   = ALU_ADD;
      end
      ST_EXEC_R: begin
        o_ctrl.aluSrcA = 1'b1;
        o_ctrl.aluSrcB = SRCB_REG;
        o_ctrl.aluOp   = i_opcode[2:0];
      end
      ST_WB_R: begin
        o_ctrl.regWrite    = 1'b1;
        o_ctrl.regDstWrite = 1'b1;
      end
      ST_MEM_ADDR: begin
        o_ctrl.aluSrcA = 1'b1;
        o_ctrl.aluSrcB = SRCB_OFFSET;
        o_ctrl.aluOp   = ALU_ADD;
      end
      ST_MEM_RD: begin
        o_ctrl.memRead = 1'b1;
        o_ctrl.iorD    = 1'b1;
      end
      ST_WB_MEM: begin
        o_ctrl.regWrite = 1'b1;
        o_ctrl.memToReg = 1'b1;
      end
      ST_MEM_WR: begin
        o_ctrl.memWrite = 1'b1;
        o_ctrl.iorD     = 1'b1;
      end
      ST_BRANCH: begin
        o_ctrl.aluSrcA     = 1'b1;
        o_ctrl.aluSrcB     = SRCB_REG;
        o_ctrl.aluOp       = ALU_SUB;
        o_ctrl.pcWriteCond = 1'b1;
        o_ctrl.pcSrc       = PCSRC_ALUOUT;
        o_ctrl.branchNe    = (i_opcode == OP_BNE);
      end
      ST_JUMP: begin
        o_ctrl.pcWrite = 1'b1;
        o_ctrl.pcSrc   = PCSRC_JUMP;
      end
      ST_HALT: o_ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control sequencer: state register, opcode latch and next-state
// logic; output decoding lives in mc_ctrl_outdec. Optional memory wait
// states are enabled with CTRL_MEMWAIT_EN.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = CTRL_STATE_W
) (
  input  logic      clk,
  input  logic      rst,
  mc_ctrl_if.master bus
);

  logic [STATE_W-1:0] r_state;
  logic [3:0]         r_opcode;
  logic               r_illegal;
  state_t             w_state;
  state_t             w_nextState;
  logic               w_memReady;
  ctrl_out_t          w_ctrl;

  assign w_state = state_t'(r_state[CTRL_STATE_W-1:0]);

`ifdef CTRL_MEMWAIT_EN
  assign w_memReady = bus.C_MemReady;
`else
  assign w_memReady = 1'b1;
`endif

  // Next-state walk; memory states only advance once memory is ready
  always_comb begin
    w_nextState = w_state;
    case (w_state)
      ST_RESET:  w_nextState = ST_FETCH;
      ST_FETCH:  if (w_memReady) w_nextState = ST_DECODE;
      ST_DECODE: begin
        if (isRType(bus.D_Opcode)) begin
          w_nextState = ST_EXEC_R;
        end else begin
          case (bus.D_Opcode)
            OP_LW, OP_SW:   w_nextState = ST_MEM_ADDR;
            OP_BEQ, OP_BNE: w_nextState = ST_BRANCH;
            OP_J:           w_nextState = ST_JUMP;
            OP_HALT:        w_nextState = ST_HALT;
            default:        w_nextState = ST_FETCH;
          endcase
        end
      end
      ST_EXEC_R:   w_nextState = ST_WB_R;
      ST_WB_R:     w_nextState = ST_FETCH;
      ST_MEM_ADDR: w_nextState = (r_opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (w_memReady) w_nextState = ST_WB_MEM;
      ST_WB_MEM:   w_nextState = ST_FETCH;
      ST_MEM_WR:   if (w_memReady) w_nextState = ST_FETCH;
      ST_BRANCH:   w_nextState = ST_FETCH;
      ST_JUMP:     w_nextState = ST_FETCH;
      ST_HALT:     w_nextState = ST_HALT;
      default:     w_nextState = ST_RESET;
    endcase
  end

  // State register; reset drops straight to RESET so all outputs clear at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= STATE_W'(ST_RESET);
    else     r_state <= STATE_W'(w_nextState);
  end

  // Opcode latch on the DECODE edge, plus a one-shot flag for an illegal opcode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opcode  <= 4'h0;
      r_illegal <= 1'b0;
    end else begin
      if (w_state == ST_DECODE) r_opcode <= bus.D_Opcode;
      r_illegal <= (w_state == ST_DECODE) && isIllegalOp(bus.D_Opcode);
    end
  end

  mc_ctrl_outdec u_outdec (
    .i_state          (w_state),
    .i_opcode         (r_opcode),
    .i_illegalPending (r_illegal),
`ifdef CTRL_MEMWAIT_EN
    .i_memReady       (w_memReady),
`endif
    .o_ctrl           (w_ctrl)
  );

  assign bus.C_IRWrite     = w_ctrl.irWrite;
  assign bus.C_IorD        = w_ctrl.iorD;
  assign bus.C_MemRead     = w_ctrl.memRead;
  assign bus.C_MemWrite    = w_ctrl.memWrite;
  assign bus.C_PCWrite     = w_ctrl.pcWrite;
  assign bus.C_PCWriteCond = w_ctrl.pcWriteCond;
  assign bus.C_BranchNe    = w_ctrl.branchNe;
  assign bus.C_PCSrc       = w_ctrl.pcSrc;
  assign bus.C_ALUSrcA     = w_ctrl.aluSrcA;
  assign bus.C_ALUSrcB     = w_ctrl.aluSrcB;
  assign bus.C_ALUOp       = w_ctrl.aluOp;
  assign bus.C_RegDstWrite = w_ctrl.regDstWrite;
  assign bus.C_RegWrite    = w_ctrl.regWrite;
  assign bus.C_MemToReg    = w_ctrl.memToReg;
  assign bus.C_Halted      = w_ctrl.halted;
  assign bus.C_Illegal     = w_ctrl.illegal;

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multicycle control sequencer for the 16-bit processor. It is the initiator side of the register-file write interface: it drives `C_RegDstWrite`, `C_RegWrite` and `C_MemToReg` into the register file. It also drives PC, IR, memory and ALU steering for the datapath. It consumes the 4-bit opcode from the instruction register and steps one state per clock through fetch, decode, execute, memory and writeback.

## Interface
Parameters:
- `STATE_W`, default 4: state register width.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `D_Opcode`  in  4  `IR[15:12]`; sampled only in DECODE.
- `C_MemReady`  in  1  memory handshake; present only with `CTRL_MEMWAIT_EN`.
- `C_IRWrite`, `C_IorD`, `C_MemRead`, `C_MemWrite`  out  1 each  memory and IR controls.
- `C_PCWrite`, `C_PCWriteCond`, `C_BranchNe`  out  1 each  PC update controls.
- `C_PCSrc`  out  2  PC source: 0 = ALU, 1 = ALUOut, 2 = jump target.
- `C_ALUSrcA`  out  1  ALU A select: 0 = PC, 1 = reg.
- `C_ALUSrcB`  out  2  ALU B select: 0 = reg, 1 = const 2, 2 = offset.
- `C_ALUOp`  out  3  ALU function.
- `C_RegDstWrite`, `C_RegWrite`, `C_MemToReg`  out  1 each  register-file write controls.
- `C_Halted`  out  1  high while in HALT.
- `C_Illegal`  out  1  one-cycle pulse on an undefined opcode.

## Operation
- Opcode map:
  - 0x0–0x7: R-type, with `C_ALUOp = opcode[2:0]`.
  - 0x8: LW. 0x9: SW. 0xA: BEQ. 0xB: BNE. 0xC: J. 0xF: HALT.
  - 0xD, 0xE: illegal.
- States are RESET, FETCH, DECODE, EXEC_R, WB_R, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP, HALT.
- Outputs are Moore: a function of the current state only. Any output not listed for a state is 0.
- RESET: all outputs 0. Next state is FETCH.
- FETCH: `MemRead=1`, `IorD=0`, `IRWrite=1`, `ALUSrcA=0`, `ALUSrcB=1`, `ALUOp=0` (add), `PCSrc=0`, `PCWrite=1`. Next state is DECODE.
- DECODE: `ALUSrcA=0`, `ALUSrcB=2`, `ALUOp=0` (precomputes the branch target). Next state by opcode:
  - R-type → EXEC_R.
  - LW, SW → MEM_ADDR.
  - BEQ, BNE → BRANCH.
  - J → JUMP.
  - HALT → HALT.
  - illegal → FETCH, with `C_Illegal` pulsed in the following FETCH cycle.
- EXEC_R: `ALUSrcA=1`, `ALUSrcB=0`, `ALUOp=opcode[2:0]` from a latched copy of the opcode. Next state is WB_R.
- WB_R: `RegWrite=1`, `RegDstWrite=1`, `MemToReg=0`. Next state is FETCH.
- MEM_ADDR: `ALUSrcA=1`, `ALUSrcB=2`, `ALUOp=0`. Next state is MEM_RD for LW, MEM_WR for SW.
- MEM_RD: `MemRead=1`, `IorD=1`. Next state is WB_MEM.
- WB_MEM: `RegWrite=1`, `RegDstWrite=0`, `MemToReg=1`. Next state is FETCH.
- MEM_WR: `MemWrite=1`, `IorD=1`. Next state is FETCH.
- BRANCH: `ALUSrcA=1`, `ALUSrcB=0`, `ALUOp=1` (sub), `PCWriteCond=1`, `PCSrc=1`; `BranchNe=1` for BNE. Next state is FETCH.
- JUMP: `PCWrite=1`, `PCSrc=2`. Next state is FETCH.
- HALT: `C_Halted=1`. HALT is absorbing; only `rst` exits it.
- The opcode is latched into an internal 4-bit register on the DECODE edge. It has no effect in any other state.

## Timing
- The state register updates on the rising `clk` edge. `rst` forces RESET immediately, with no clock needed.
- Asserting `rst` mid-instruction abandons the instruction: all outputs go to 0 combinationally, and no partial `RegWrite` or `MemWrite` is left asserted.
- The first FETCH occurs in the first cycle after the first clock edge following `rst` deassertion.
- Cycles per instruction: R-type 4, LW 5, SW 4, BEQ/BNE 3, J 3, illegal 2.
- `C_RegWrite` is high for exactly one cycle per R-type or LW instruction and is never high in any other state.

## Configuration
- `CTRL_MEMWAIT_EN` defined:
  - The `C_MemReady` port exists.
  - FETCH, MEM_RD and MEM_WR hold their state and outputs while `C_MemReady=0`.
  - `PCWrite` and `IRWrite` in FETCH are gated by `C_MemReady`, so the PC advances exactly once per fetch.
- `CTRL_MEMWAIT_EN` undefined: the port is absent and each memory state lasts exactly one cycle.

## Structure
- `mc_ctrl_pkg` holds:
  - state encodings (localparams, `STATE_W` bits);
  - opcode constants (`OP_LW`, `OP_SW`, `OP_BEQ`, `OP_BNE`, `OP_J`, `OP_HALT`);
  - ALU op codes `ALU_ADD=0`, `ALU_SUB=1`;
  - `PCSrc` and `ALUSrcB` encodings.
- Sub-module `mc_ctrl_outdec`: purely combinational mapping from state and latched opcode to all outputs. The top level holds the state register, the opcode latch and the next-state logic.

## Test plan
- Reset: hold `rst=1` → all outputs 0. Release it → FETCH outputs one edge later (`PCWrite=1`, `IRWrite=1`).
- R-type: `D_Opcode=0x3` → states FETCH, DECODE, EXEC_R (`ALUOp=3`), WB_R (`RegWrite=1`, `RegDstWrite=1`, `MemToReg=0`); returns to FETCH on cycle 5.
- LW then SW:
  - opcode 0x8 → WB_MEM in cycle 5 with `RegWrite=1`, `MemToReg=1`, `RegDstWrite=0`;
  - opcode 0x9 → `MemWrite=1` in cycle 4, and `RegWrite` never asserted.
- BNE and illegal:
  - opcode 0xB → BRANCH with `PCWriteCond=1`, `BranchNe=1`, `PCSrc=1`;
  - opcode 0xD → back to FETCH with `C_Illegal=1` for one cycle.
- HALT and reset mid-instruction:
  - opcode 0xF → `C_Halted` stays 1 for 20 cycles;
  - pulse `rst` during WB_MEM → `RegWrite` drops to 0 before the next edge.
- `CTRL_MEMWAIT_EN`: hold `C_MemReady=0` for 3 cycles in MEM_RD → the state holds; WB_MEM follows the edge on which `C_MemReady=1`.
